// File: rtl/mem_stack_sequencer.sv
// Stack push/pop sequencer in front of MemoryStage for CALL/INT/RET/RTI.
// Define SEQ_PROTECT_EN to add a stack-depth counter with underflow abort (seq_err).
module mem_stack_sequencer #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 32,
    parameter int DEPTH_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_mem_read,
    input  logic              pipe_mem_write,
    input  logic              pipe_sp_or_alu,
    input  logic [1:0]        pipe_sp_op,
    input  logic [DATA_W-1:0] pipe_reg_src,
    input  logic              req_call,
    input  logic              req_int,
    input  logic              req_ret,
    input  logic              req_rti,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [DATA_W-1:0] flags_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              sp_or_alu,
    output logic [1:0]        sp_op,
    output logic [DATA_W-1:0] reg_src,
    output logic              stall,
    output logic              seq_ack,
    output logic              seq_done,
    output logic [PC_W-1:0]   pc_out,
    output logic              pc_valid,
    output logic [DATA_W-1:0] flags_out,
    output logic              flags_valid,
    output logic              seq_err
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_PCH,
        PUSH_PCL,
        PUSH_FLG,
        POP_FLG,
        POP_PCL,
        POP_PCH,
        CAP_LAST
    } state_e;

    localparam logic [1:0] SP_PUSH = 2'b01;
    localparam logic [1:0] SP_POP  = 2'b10;

    state_e            state_q, state_d;
    logic              is_int_q, is_int_d;
    logic              is_rti_q, is_rti_d;
    logic              defer_q, defer_d;
    logic [DATA_W-1:0] pc_lo_q, pc_lo_d;
    logic [DATA_W-1:0] pc_hi_q, pc_hi_d;
    logic [DATA_W-1:0] flags_q, flags_d;
    logic              flags_valid_q, flags_valid_d;

    logic req_any;
    logic pipe_op;
    logic accept;
    logic abort;
    logic pipe_pop_uflow;

    assign req_any = req_int | req_call | req_rti | req_ret;
    assign pipe_op = pipe_mem_read | pipe_mem_write;
    // defer_q marks the cycle after a pipe op collided with a request: the op
    // already issued, so the still-presented pipe op is not issued again.
    assign accept  = (state_q == IDLE) && req_any && (!pipe_op || defer_q);

`ifdef SEQ_PROTECT_EN
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               push_evt, pop_evt;

    always_comb begin
        abort = 1'b0;
        if (accept && !req_int && !req_call) begin
            if (req_rti) begin
                abort = (depth_q < DEPTH_W'(3));
            end else begin
                abort = (depth_q < DEPTH_W'(2));
            end
        end
    end

    assign pipe_pop_uflow = (state_q == IDLE) && !defer_q && pipe_mem_read &&
                            (pipe_sp_op == SP_POP) && (depth_q == '0);

    assign push_evt = mem_write && (sp_op == SP_PUSH);
    assign pop_evt  = mem_read && (sp_op == SP_POP);

    always_comb begin
        depth_d = depth_q;
        if (push_evt && !pop_evt) begin
            if (depth_q != '1) begin
                depth_d = depth_q + DEPTH_W'(1);
            end
        end else if (pop_evt && !push_evt) begin
            if (depth_q != '0) begin
                depth_d = depth_q - DEPTH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end
`else
    logic [DEPTH_W-1:0] unused_depth;

    assign unused_depth   = '0;
    assign abort          = 1'b0;
    assign pipe_pop_uflow = 1'b0;
`endif

    // State register and captured data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            is_int_q      <= 1'b0;
            is_rti_q      <= 1'b0;
            defer_q       <= 1'b0;
            pc_lo_q       <= '0;
            pc_hi_q       <= '0;
            flags_q       <= '0;
            flags_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            is_int_q      <= is_int_d;
            is_rti_q      <= is_rti_d;
            defer_q       <= defer_d;
            pc_lo_q       <= pc_lo_d;
            pc_hi_q       <= pc_hi_d;
            flags_q       <= flags_d;
            flags_valid_q <= flags_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        is_int_d = is_int_q;
        is_rti_d = is_rti_q;
        defer_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && !abort) begin
                    is_int_d = req_int;
                    is_rti_d = !req_int && !req_call && req_rti;
                    if (req_int || req_call) begin
                        state_d = PUSH_PCH;
                    end else if (req_rti) begin
                        state_d = POP_FLG;
                    end else begin
                        state_d = POP_PCL;
                    end
                end else if (req_any && pipe_op && !defer_q) begin
                    defer_d = 1'b1;
                end
            end
            PUSH_PCH: state_d = PUSH_PCL;
            PUSH_PCL: state_d = is_int_q ? PUSH_FLG : IDLE;
            PUSH_FLG: state_d = IDLE;
            POP_FLG:  state_d = POP_PCL;
            POP_PCL:  state_d = POP_PCH;
            POP_PCH:  state_d = CAP_LAST;
            CAP_LAST: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Read data arrives one cycle after each pop is issued
    always_comb begin
        pc_lo_d       = pc_lo_q;
        pc_hi_d       = pc_hi_q;
        flags_d       = flags_q;
        flags_valid_d = (state_q == POP_PCL) && is_rti_q;
        if (state_q == POP_PCH) begin
            pc_lo_d = mem_rdata;
        end
        if (state_q == CAP_LAST) begin
            pc_hi_d = mem_rdata;
        end
        if (flags_valid_d) begin
            flags_d = mem_rdata;
        end
    end

    // Output logic
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        sp_or_alu   = 1'b0;
        sp_op       = 2'b00;
        reg_src     = '0;
        stall       = 1'b0;
        seq_ack     = 1'b0;
        seq_done    = 1'b0;
        pc_out      = '0;
        pc_valid    = 1'b0;
        flags_out   = '0;
        flags_valid = 1'b0;
        seq_err     = 1'b0;
        if (rst) begin
            stall = (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (!defer_q) begin
                        mem_read  = pipe_mem_read;
                        mem_write = pipe_mem_write;
                        sp_or_alu = pipe_sp_or_alu;
                        sp_op     = pipe_sp_op;
                        reg_src   = pipe_reg_src;
                    end
                    stall   = req_any;
                    seq_ack = accept;
                    seq_err = abort | pipe_pop_uflow;
                end
                PUSH_PCH: begin
                    mem_write = 1'b1;
                    sp_op     = SP_PUSH;
                    reg_src   = pc_in[PC_W-1:DATA_W];
                end
                PUSH_PCL: begin
                    mem_write = 1'b1;
                    sp_op     = SP_PUSH;
                    reg_src   = pc_in[DATA_W-1:0];
                    seq_done  = !is_int_q;
                end
                PUSH_FLG: begin
                    mem_write = 1'b1;
                    sp_op     = SP_PUSH;
                    reg_src   = flags_in;
                    seq_done  = 1'b1;
                end
                POP_FLG, POP_PCL, POP_PCH: begin
                    mem_read = 1'b1;
                    sp_op    = SP_POP;
                end
                CAP_LAST: begin
                    pc_valid = 1'b1;
                    seq_done = 1'b1;
                end
                default: begin
                    stall = 1'b1;
                end
            endcase
            // Upper PC half is forwarded straight from memory in CAP_LAST so it
            // is valid together with pc_valid; afterwards the captured copy holds.
            pc_out      = {(state_q == CAP_LAST) ? mem_rdata : pc_hi_q, pc_lo_q};
            flags_out   = flags_q;
            flags_valid = flags_valid_q;
        end
    end

endmodule

// File: doc/mem_stack_sequencer.md
Name: mem_stack_sequencer

Overview:
- Controller in front of MemoryStage that owns its control inputs (MemRead, MemWrite, SPOrALUres, SPOpeartion, RegSrc).
- In idle it passes the pipeline's single-cycle memory request straight through.
- On CALL/INT/RET/RTI it stalls the pipeline and runs multi-word push/pop sequences for the 32-bit PC and the flags word, then returns the popped values to fetch/flag logic.

Parameters:
- DATA_W, 16, memory word width.
- PC_W, 32, program counter width; always 2*DATA_W.
- DEPTH_W, 8, stack-depth counter width; used only with SEQ_PROTECT_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- pipe_mem_read  in  1  pipeline load/pop request.
- pipe_mem_write  in  1  pipeline store/push request.
- pipe_sp_or_alu  in  1  pipeline address select (1=ALU result, 0=SP).
- pipe_sp_op  in  2  pipeline SP op (00 none, 01 push, 10 pop).
- pipe_reg_src  in  DATA_W  pipeline write data.
- req_call, req_int, req_ret, req_rti  in  1 each  sequence requests; held until ack.
- pc_in  in  PC_W  PC to save.
- flags_in  in  DATA_W  flags to save.
- mem_rdata  in  DATA_W  MemoryStage Data output; valid the cycle after a read is issued.
- mem_read, mem_write, sp_or_alu  out  1 each  to MemoryStage.
- sp_op  out  2  to MemoryStage.
- reg_src  out  DATA_W  to MemoryStage.
- stall  out  1  freeze IF/ID/EX.
- seq_ack  out  1  one-cycle pulse: request accepted.
- seq_done  out  1  one-cycle pulse: sequence complete.
- pc_out  out  PC_W  restored PC.
- pc_valid  out  1  pulse.
- flags_out  out  DATA_W  restored flags.
- flags_valid  out  1  pulse.
- seq_err  out  1  pulse, underflow abort (SEQ_PROTECT_EN only).

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; pc_out/flags_out cleared. Reset mid-sequence abandons it: no done, no valid pulses.
- States: IDLE, PUSH_PCH, PUSH_PCL, PUSH_FLG, POP_FLG, POP_PCL, POP_PCH, CAP_LAST.
- IDLE:
  - Memory outputs equal the pipe_* inputs, combinationally. stall=0 unless a request is accepted.
  - Request priority: INT > CALL > RTI > RET.
  - If no pipe op (pipe_mem_read=pipe_mem_write=0): accept the request. seq_ack=1 and stall=1 that cycle; next state is the first state of the sequence.
  - If a pipe op is present: the pipe op issues this cycle, stall=1, no ack; the request is accepted next cycle.
- Push cycle: mem_write=1, sp_or_alu=0, sp_op=01, reg_src=word.
- Pop cycle: mem_read=1, sp_or_alu=0, sp_op=10, reg_src=0.
- CALL: PUSH_PCH (pc_in[31:16]) -> PUSH_PCL (pc_in[15:0]). seq_done in PUSH_PCL, then IDLE. 2 cycles.
- INT: PUSH_PCH -> PUSH_PCL -> PUSH_FLG (flags_in). seq_done in PUSH_FLG. 3 cycles.
- RET: POP_PCL -> POP_PCH -> CAP_LAST. 3 cycles.
  - mem_rdata sampled in POP_PCH -> pc_out[15:0].
  - mem_rdata sampled in CAP_LAST -> pc_out[31:16].
  - pc_valid and seq_done in CAP_LAST.
- RTI: POP_FLG -> POP_PCL -> POP_PCH -> CAP_LAST. 4 cycles.
  - Flags captured in POP_PCL; flags_valid pulses the cycle after POP_PCL.
  - pc_valid and seq_done in CAP_LAST.
- CAP_LAST issues no memory op.
- stall=1 in every non-IDLE state. pipe_* inputs are ignored while busy.
- pc_in and flags_in are sampled at push issue; requesters hold them stable until seq_done.
- Requests asserted during a sequence are ignored until back in IDLE. Requesters drop req after seq_ack; a still-held req restarts a new sequence.
- No SP arithmetic in this block; SP wrap-around is MemoryStage's responsibility.

Optional Feature:
- Macro: SEQ_PROTECT_EN.
- Defined:
  - A DEPTH_W-bit depth counter, reset to 0.
  - +1 per push issued by this block or passed through. -1 per pop. Saturates at all-ones.
  - If an accepted RET needs depth<2, or an accepted RTI needs depth<3: abort. seq_ack=1 and seq_err=1 that cycle, no memory ops, no stall beyond that cycle, no done/valid pulses, state stays IDLE.
  - A pass-through pop at depth 0 still issues and raises seq_err; the counter stays 0.
- Not defined: no counter; seq_err tied 0; pops are never checked.

Test Plan:
- Pass-through: IDLE, pipe write RegSrc=4 to ALU addr 2 -> mem_write=1, sp_or_alu=1, reg_src=4 same cycle, stall=0; then pipe read -> mem_read=1.
- CALL then RET: pc_in=32'h0001_0020 -> pushes 16'h0001 then 16'h0020, stall 2 cycles. RET with mem_rdata 16'h0020 then 16'h0001 -> pc_out=32'h0001_0020, pc_valid on cycle 3.
- INT then RTI: pc_in=32'h0000_00A5, flags_in=16'h0005 -> 3 pushes in order PCH, PCL, FLG. RTI -> flags_out=16'h0005 and pc_out=32'h0000_00A5, seq_done on cycle 4.
- Collision: pipe push of 16 and req_int in the same cycle -> pipe push issues first, seq_ack next cycle, INT sequence follows. Simultaneous req_int+req_call -> INT served.
- Reset mid-RTI: drop rst in POP_PCL -> all outputs 0 immediately; no pc_valid; IDLE after release.
- SEQ_PROTECT_EN: from reset, req_ret -> seq_err=1, no mem_read. After CALL, RET completes with seq_err=0.
